// File: rtl/fish_render_arbiter.sv
// rtl/fish_render_arbiter.sv - shared-ROM fish sprite arbiter and compositor
// Optional FISH_FLIP_EN: per-fish horizontal mirroring of the sprite column.
module fish_render_arbiter #(
  parameter int NUM_FISH = 4,
  parameter int SPR_W    = 15,
  parameter int SPR_H    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hc,
  input  logic [9:0]  vc,
  input  logic        bright,
  input  logic        frame_start,
  input  logic [11:0] bg_color,
  input  logic        pos_wr_en,
  input  logic [2:0]  pos_wr_idx,
  input  logic [9:0]  pos_wr_x,
  input  logic [9:0]  pos_wr_y,
  input  logic        pos_wr_vis,
  input  logic        pos_wr_flip,
  output logic [2:0]  spr_row,
  output logic [3:0]  spr_col,
  input  logic [11:0] spr_data,
  output logic [11:0] rgb,
  output logic        collision
);

  logic [9:0]          sh_x  [NUM_FISH];
  logic [9:0]          sh_y  [NUM_FISH];
  logic [9:0]          act_x [NUM_FISH];
  logic [9:0]          act_y [NUM_FISH];
  logic [NUM_FISH-1:0] sh_vis, act_vis;

  logic [9:0]          dx [NUM_FISH];
  logic [9:0]          dy [NUM_FISH];
  logic [NUM_FISH-1:0] hit;
  logic                any_hit, multi_hit;
  logic [3:0]          dx_win, col_win;
  logic [2:0]          dy_win;

  logic                s1_hit, s1_bright, s1_multi;
  logic [11:0]         s1_bg;
  logic                s2_hit, s2_bright;
  logic [11:0]         s2_bg;
  logic                coll_acc, coll_set;

`ifdef FISH_FLIP_EN
  logic [NUM_FISH-1:0] sh_flip, act_flip;
  logic                flip_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_flip  <= '0;
      act_flip <= '0;
    end else begin
      for (int i = 0; i < NUM_FISH; i++) begin
        if (frame_start) act_flip[i] <= sh_flip[i];
        if (pos_wr_en && pos_wr_idx == 3'(i)) sh_flip[i] <= pos_wr_flip;
      end
    end
  end

  assign col_win = flip_win ? 4'(SPR_W - 1) - dx_win : dx_win;
`else
  logic unused_flip;
  assign unused_flip = pos_wr_flip;
  assign col_win     = dx_win;
`endif

  // Commit reads the shadow before any same-edge write lands in it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FISH; i++) begin
        sh_x[i]  <= '0;
        sh_y[i]  <= '0;
        act_x[i] <= '0;
        act_y[i] <= '0;
      end
      sh_vis  <= '0;
      act_vis <= '0;
    end else begin
      for (int i = 0; i < NUM_FISH; i++) begin
        if (frame_start) begin
          act_x[i]   <= sh_x[i];
          act_y[i]   <= sh_y[i];
          act_vis[i] <= sh_vis[i];
        end
        if (pos_wr_en && pos_wr_idx == 3'(i)) begin
          sh_x[i]   <= pos_wr_x;
          sh_y[i]   <= pos_wr_y;
          sh_vis[i] <= pos_wr_vis;
        end
      end
    end
  end

  // Unsigned wrap makes pixels left of / above a fish miss naturally.
  always_comb begin
    for (int i = 0; i < NUM_FISH; i++) begin
      dx[i]  = hc - act_x[i];
      dy[i]  = vc - act_y[i];
      hit[i] = act_vis[i] && (dx[i] < 10'(SPR_W)) && (dy[i] < 10'(SPR_H));
    end
  end

  always_comb begin
    any_hit   = 1'b0;
    multi_hit = 1'b0;
    dx_win    = '0;
    dy_win    = '0;
`ifdef FISH_FLIP_EN
    flip_win  = 1'b0;
`endif
    for (int i = 0; i < NUM_FISH; i++) begin
      if (hit[i]) begin
        if (any_hit) begin
          multi_hit = 1'b1;
        end else begin
          dx_win = dx[i][3:0];
          dy_win = dy[i][2:0];
`ifdef FISH_FLIP_EN
          flip_win = act_flip[i];
`endif
        end
        any_hit = 1'b1;
      end
    end
  end

  assign coll_set = s1_multi & s1_bright;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spr_row   <= '0;
      spr_col   <= '0;
      s1_hit    <= 1'b0;
      s1_bright <= 1'b0;
      s1_multi  <= 1'b0;
      s1_bg     <= '0;
      s2_hit    <= 1'b0;
      s2_bright <= 1'b0;
      s2_bg     <= '0;
      rgb       <= '0;
      coll_acc  <= 1'b0;
      collision <= 1'b0;
    end else begin
      if (any_hit) begin
        spr_row <= dy_win;
        spr_col <= col_win;
      end
      s1_hit    <= any_hit;
      s1_bright <= bright;
      s1_multi  <= multi_hit;
      s1_bg     <= bg_color;
      s2_hit    <= s1_hit;
      s2_bright <= s1_bright;
      s2_bg     <= s1_bg;
      if (!s2_bright)                              rgb <= '0;
      else if (!s2_hit || spr_data == 12'h000)     rgb <= s2_bg;
      else                                         rgb <= spr_data;
      if (frame_start) begin
        collision <= coll_acc | coll_set;
        coll_acc  <= 1'b0;
      end else if (coll_set) begin
        coll_acc  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fish_render_arbiter.sv
// tb/tb_fish_render_arbiter.sv - randomized self-checking bench for fish_render_arbiter
module tb_fish_render_arbiter;
  localparam int NF = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  hc = '0, vc = '0;
  logic        bright = 1'b0, frame_start = 1'b0;
  logic [11:0] bg_color = '0;
  logic        pos_wr_en = 1'b0;
  logic [2:0]  pos_wr_idx = '0;
  logic [9:0]  pos_wr_x = '0, pos_wr_y = '0;
  logic        pos_wr_vis = 1'b0, pos_wr_flip = 1'b0;
  logic [2:0]  spr_row;
  logic [3:0]  spr_col;
  logic [11:0] spr_data;
  logic [11:0] rgb;
  logic        collision;

  int errors = 0;
  int checks = 0;

  int m_sx [NF], m_sy [NF], m_ax [NF], m_ay [NF];
  bit m_svis [NF], m_sflip [NF], m_avis [NF], m_aflip [NF];
  bit m_acc;
  logic exp_coll;
  logic [11:0] exp_q [$];

  always #5 clk = ~clk;

  fish_render_arbiter #(.NUM_FISH(NF), .SPR_W(15), .SPR_H(8)) dut (
    .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc), .bright(bright),
    .frame_start(frame_start), .bg_color(bg_color), .pos_wr_en(pos_wr_en),
    .pos_wr_idx(pos_wr_idx), .pos_wr_x(pos_wr_x), .pos_wr_y(pos_wr_y),
    .pos_wr_vis(pos_wr_vis), .pos_wr_flip(pos_wr_flip), .spr_row(spr_row),
    .spr_col(spr_col), .spr_data(spr_data), .rgb(rgb), .collision(collision)
  );

  function automatic logic [11:0] rom_val(input logic [2:0] r, input logic [3:0] c);
    if ((int'(r) + int'(c)) % 4 == 0) return 12'h000;
    return {r, c, 5'(int'(r) * 7 + int'(c) * 3)};
  endfunction

  // Sprite ROM: registered address, data one cycle later.
  always_ff @(posedge clk) spr_data <= rom_val(spr_row, spr_col);

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_sx[i] = 0; m_sy[i] = 0; m_ax[i] = 0; m_ay[i] = 0;
      m_svis[i] = 0; m_sflip[i] = 0; m_avis[i] = 0; m_aflip[i] = 0;
    end
    m_acc = 0;
    exp_coll = 1'b0;
    exp_q.delete();
  endtask

  task automatic step(input int h, input int v, input bit br, input logic [11:0] bg,
                      input bit fs, input bit wr, input int idx, input int wx, input int wy,
                      input bit wvis, input bit wflip);
    int win, nh, er, ec;
    logic [11:0] rv, e, e0;
    win = -1; nh = 0; er = 0; ec = 0; rv = 12'h000;
    for (int i = 0; i < NF; i++)
      if (m_avis[i] && h >= m_ax[i] && h < m_ax[i] + 15 && v >= m_ay[i] && v < m_ay[i] + 8) begin
        nh++;
        if (win < 0) win = i;
      end
    if (win >= 0) begin
      er = v - m_ay[win];
      ec = h - m_ax[win];
`ifdef FISH_FLIP_EN
      if (m_aflip[win]) ec = 14 - ec;
`endif
      rv = rom_val(3'(er), 4'(ec));
    end
    if (!br) e = 12'h000;
    else if (win < 0 || rv == 12'h000) e = bg;
    else e = rv;
    exp_q.push_back(e);
    // Pixels driven before the pulse belong to the frame it closes.
    if (fs) begin
      exp_coll = m_acc;
      m_acc = 0;
      m_ax = m_sx; m_ay = m_sy; m_avis = m_svis; m_aflip = m_sflip;
    end
    if (br && nh >= 2) m_acc = 1;
    if (wr && idx < NF) begin
      m_sx[idx] = wx; m_sy[idx] = wy; m_svis[idx] = wvis; m_sflip[idx] = wflip;
    end
    hc = 10'(h); vc = 10'(v); bright = br; bg_color = bg; frame_start = fs;
    pos_wr_en = wr; pos_wr_idx = 3'(idx); pos_wr_x = 10'(wx); pos_wr_y = 10'(wy);
    pos_wr_vis = wvis; pos_wr_flip = wflip;
    @(posedge clk); #1;
    if (win >= 0) begin
      checks++;
      if (spr_row !== 3'(er) || spr_col !== 4'(ec)) begin
        errors++;
        $display("FAIL rom_addr at (%0d,%0d): got row=%0d col=%0d expected row=%0d col=%0d",
                 h, v, spr_row, spr_col, er, ec);
      end
    end
    if (exp_q.size() == 3) begin
      e0 = exp_q.pop_front();
      checks++;
      if (rgb !== e0) begin
        errors++;
        $display("FAIL rgb at t=%0t: got %h expected %h", $time, rgb, e0);
      end
    end
    checks++;
    if (collision !== exp_coll) begin
      errors++;
      $display("FAIL collision at t=%0t: got %b expected %b", $time, collision, exp_coll);
    end
  endtask

  task automatic pix(input int h, input int v, input bit br);
    step(h, v, br, 12'($urandom), 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(700, 500, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fs_pulse();
    step(700, 500, 0, 12'h000, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_pos(input int idx, input int x, input int y, input bit vis, input bit flip);
    step(700, 500, 0, 12'h000, 0, 1, idx, x, y, vis, flip);
  endtask

  task automatic sweep(input int x0, input int x1, input int v);
    for (int h = x0; h <= x1; h++) pix(h, v, 1);
    idle(3);
  endtask

  task automatic test_reset();
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (rgb !== 12'h000)   begin errors++; $display("FAIL reset_rgb: got %h expected 000", rgb); end
    if (spr_row !== 3'd0)  begin errors++; $display("FAIL reset_row: got %0d expected 0", spr_row); end
    if (spr_col !== 4'd0)  begin errors++; $display("FAIL reset_col: got %0d expected 0", spr_col); end
    if (collision !== 1'b0) begin errors++; $display("FAIL reset_coll: got %b expected 0", collision); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_sweep();
    wr_pos(0, 100, 50, 1, 0);
    fs_pulse();
    sweep(98, 116, 52);
  endtask

  task automatic test_shadow_write();
    wr_pos(1, 200, 60, 1, 0);
    sweep(200, 214, 60);
    fs_pulse();
    sweep(199, 215, 60);
    sweep(200, 214, 67);
  endtask

  task automatic test_overlap();
    wr_pos(0, 300, 100, 1, 0);
    wr_pos(1, 300, 100, 1, 0);
    fs_pulse();
    sweep(298, 316, 103);
    wr_pos(1, 400, 200, 1, 0);
    fs_pulse();
    checks++;
    if (collision !== 1'b1) begin errors++; $display("FAIL overlap_coll_set: got %b expected 1", collision); end
    sweep(298, 316, 103);
    sweep(400, 414, 201);
    fs_pulse();
    checks++;
    if (collision !== 1'b0) begin errors++; $display("FAIL overlap_coll_clear: got %b expected 0", collision); end
  endtask

  task automatic test_edge();
    wr_pos(3, 630, 10, 1, 0);
    fs_pulse();
    sweep(626, 639, 12);
    sweep(0, 4, 13);
    sweep(628, 639, 18);
  endtask

  task automatic test_coincident();
    wr_pos(2, 50, 300, 1, 0);
    fs_pulse();
    step(700, 500, 0, 12'h000, 1, 1, 2, 60, 310, 1, 0);
    sweep(50, 64, 302);
    sweep(60, 74, 312);
    fs_pulse();
    sweep(50, 64, 302);
    sweep(60, 74, 312);
    wr_pos(5, 500, 400, 1, 0);
    fs_pulse();
    sweep(500, 514, 402);
    sweep(400, 414, 202);
  endtask

  task automatic test_flip();
    wr_pos(0, 100, 50, 1, 1);
    fs_pulse();
    sweep(100, 114, 51);
    wr_pos(0, 100, 50, 1, 0);
    fs_pulse();
  endtask

  task automatic test_reset_async();
    wr_pos(0, 300, 100, 1, 0);
    wr_pos(1, 300, 100, 1, 0);
    fs_pulse();
    for (int h = 301; h <= 305; h++) pix(h, 101, 1);
    fs_pulse();
    for (int h = 301; h <= 305; h++) pix(h, 101, 1);
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (rgb !== 12'h000)    begin errors++; $display("FAIL async_rst_rgb: got %h expected 000", rgb); end
    if (collision !== 1'b0) begin errors++; $display("FAIL async_rst_coll: got %b expected 0", collision); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    sweep(300, 314, 101);
    fs_pulse();
    sweep(300, 314, 101);
  endtask

  task automatic test_random(input bit clustered);
    for (int i = 0; i < NF; i++) begin
      if (clustered) wr_pos(i, 100 + int'($urandom_range(0, 30)), 100 + int'($urandom_range(0, 10)),
                            $urandom_range(0, 5) != 0, 1'($urandom));
      else           wr_pos(i, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                            $urandom_range(0, 5) != 0, 1'($urandom));
    end
    fs_pulse();
    for (int n = 0; n < 600; n++) begin
      int t, h, v, r;
      t = int'($urandom_range(0, NF - 1));
      h = m_ax[t] + int'($urandom_range(0, 20)) - 3;
      v = m_ay[t] + int'($urandom_range(0, 11)) - 2;
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      r = int'($urandom_range(0, 99));
      if (r < 2)
        step(h, v, 1'($urandom), 12'($urandom), 1, 0, 0, 0, 0, 0, 0);
      else if (r < 5)
        step(h, v, 1'($urandom), 12'($urandom), r == 4, 1, int'($urandom_range(0, 7)),
             clustered ? 100 + int'($urandom_range(0, 30)) : int'($urandom_range(0, 639)),
             clustered ? 100 + int'($urandom_range(0, 10)) : int'($urandom_range(0, 479)),
             1'($urandom), 1'($urandom));
      else
        step(h, v, $urandom_range(0, 7) != 0, 12'($urandom), 0, 0, 0, 0, 0, 0, 0);
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_shadow_write();
    test_overlap();
    test_edge();
    test_coincident();
    test_flip();
    test_reset_async();
    test_random(1'b1);
    test_random(1'b0);
    test_random(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
